bg_reg_file: RTL and testbench

- CPU-facing writer for the background register block (I/O offsets 0x08–0x3F).
- Captures bus writes into BGxCNT, BGxHOFS/VOFS, affine PA–PD and BG2/BG3 X/Y reference registers.
- Maintains the internal affine reference-point counters: reloaded on write and at vblank, stepped by PB/PD once per scanline.
- Drives the flat register outputs that the BG processing circuit's per-background register decode consumes.

---
 rtl/bg_reg_file_if.sv | 24 ++
 rtl/bg_reg_file.sv | 188 ++++++++++++++++++
 tb/tb_bg_reg_file.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_reg_file_if.sv
// CPU bus bundle for the background register block.
// master: CPU side driving writes/reads; slave: register file returning read data.
interface bg_reg_file_if #(
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/bg_reg_file.sv
// Background register block writer (I/O 0x08-0x3F) with affine reference counters.
// Ports: clock/reset, bus (slave), vblank_start/line_done pulses, flat BG register outputs.
module bg_reg_file #(
    parameter int ADDR_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    bg_reg_file_if.slave bus,
    input  logic         vblank_start,
    input  logic         line_done,
    output logic [15:0]  bg0cnt, bg1cnt, bg2cnt, bg3cnt,
    output logic [15:0]  bg0hofs, bg1hofs, bg2hofs, bg3hofs,
    output logic [15:0]  bg0vofs, bg1vofs, bg2vofs, bg3vofs,
    output logic [15:0]  bg2pa, bg2pb, bg2pc, bg2pd,
    output logic [15:0]  bg3pa, bg3pb, bg3pc, bg3pd,
    output logic [27:0]  bg2x, bg2y, bg3x, bg3y
);
    localparam logic [15:0] CNT_MASK = 16'hFFCF;

    logic [15:0] cnt_q [4], cnt_d [4];
    logic [8:0]  hofs_q[4], hofs_d[4];
    logic [8:0]  vofs_q[4], vofs_d[4];
    // aff[g][j]: g=0 BG2, g=1 BG3; j = PA,PB,PC,PD
    logic [15:0] aff_q[2][4], aff_d[2][4];
    // counter index: 0 BG2X, 1 BG2Y, 2 BG3X, 3 BG3Y
    logic [27:0] lat_q[4], lat_d[4];
    logic [27:0] ref_q[4], ref_d[4];
    logic [15:0] step[4];
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic [ADDR_W-1:0] wr_a, rd_a;
    logic [5:0]  wa, ra;
    logic [31:0] m;
    logic [3:0]  wr_ref;
    logic        unused_addr;

    assign wr_a = bus.wr_addr;
    assign rd_a = bus.rd_addr;
    assign wa   = wr_a[7:2];
    assign ra   = rd_a[7:2];
    assign unused_addr = ^{wr_a[1:0], rd_a[1:0]};

    assign step[0] = aff_q[0][1];
    assign step[1] = aff_q[0][3];
    assign step[2] = aff_q[1][1];
    assign step[3] = aff_q[1][3];

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k]  = cnt_q[k];
            hofs_d[k] = hofs_q[k];
            vofs_d[k] = vofs_q[k];
            lat_d[k]  = lat_q[k];
            ref_d[k]  = ref_q[k];
        end
        for (int g = 0; g < 2; g++)
            for (int j = 0; j < 4; j++)
                aff_d[g][j] = aff_q[g][j];
        m      = '0;
        wr_ref = '0;

        if (bus.wr_en) begin
            case (wa)
                6'd2, 6'd3: begin
                    m = merge({cnt_q[{wa[0], 1'b1}], cnt_q[{wa[0], 1'b0}]},
                              bus.wr_data, bus.wr_be);
                    cnt_d[{wa[0], 1'b0}] = m[15:0] & CNT_MASK;
                    cnt_d[{wa[0], 1'b1}] = m[31:16] & CNT_MASK;
                end
                6'd4, 6'd5, 6'd6, 6'd7: begin
                    m = merge({7'd0, vofs_q[wa[1:0]], 7'd0, hofs_q[wa[1:0]]},
                              bus.wr_data, bus.wr_be);
                    hofs_d[wa[1:0]] = m[8:0];
                    vofs_d[wa[1:0]] = m[24:16];
                end
                6'd8, 6'd9, 6'd12, 6'd13: begin
                    m = merge({aff_q[wa[2]][{wa[0], 1'b1}],
                               aff_q[wa[2]][{wa[0], 1'b0}]},
                              bus.wr_data, bus.wr_be);
                    aff_d[wa[2]][{wa[0], 1'b0}] = m[15:0];
                    aff_d[wa[2]][{wa[0], 1'b1}] = m[31:16];
                end
                6'd10, 6'd11, 6'd14, 6'd15: begin
                    m = merge({4'd0, lat_q[{wa[2], wa[0]}]},
                              bus.wr_data, bus.wr_be);
                    wr_ref[{wa[2], wa[0]}] = |bus.wr_be;
                end
                default: m = '0;
            endcase
        end

        // CPU write beats vblank reload, which beats the scanline step.
        // The step uses the registered PB/PD, so same-cycle writes apply later.
        for (int k = 0; k < 4; k++) begin
            if (wr_ref[k]) begin
                lat_d[k] = m[27:0];
                ref_d[k] = m[27:0];
            end else if (vblank_start) begin
                ref_d[k] = lat_q[k];
            end else if (line_done) begin
                ref_d[k] = ref_q[k] + {{12{step[k][15]}}, step[k]};
            end
        end

        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) begin
            case (ra)
                6'd2:    rd_data_d = {cnt_q[1], cnt_q[0]};
                6'd3:    rd_data_d = {cnt_q[3], cnt_q[2]};
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k]  <= '0;
                hofs_q[k] <= '0;
                vofs_q[k] <= '0;
                lat_q[k]  <= '0;
                ref_q[k]  <= '0;
            end
            for (int g = 0; g < 2; g++) begin
                aff_q[g][0] <= 16'h0100;
                aff_q[g][1] <= '0;
                aff_q[g][2] <= '0;
                aff_q[g][3] <= 16'h0100;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k]  <= cnt_d[k];
                hofs_q[k] <= hofs_d[k];
                vofs_q[k] <= vofs_d[k];
                lat_q[k]  <= lat_d[k];
                ref_q[k]  <= ref_d[k];
            end
            for (int g = 0; g < 2; g++)
                for (int j = 0; j < 4; j++)
                    aff_q[g][j] <= aff_d[g][j];
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    assign bg0cnt  = cnt_q[0];
    assign bg1cnt  = cnt_q[1];
    assign bg2cnt  = cnt_q[2];
    assign bg3cnt  = cnt_q[3];
    assign bg0hofs = {7'd0, hofs_q[0]};
    assign bg1hofs = {7'd0, hofs_q[1]};
    assign bg2hofs = {7'd0, hofs_q[2]};
    assign bg3hofs = {7'd0, hofs_q[3]};
    assign bg0vofs = {7'd0, vofs_q[0]};
    assign bg1vofs = {7'd0, vofs_q[1]};
    assign bg2vofs = {7'd0, vofs_q[2]};
    assign bg3vofs = {7'd0, vofs_q[3]};
    assign bg2pa   = aff_q[0][0];
    assign bg2pb   = aff_q[0][1];
    assign bg2pc   = aff_q[0][2];
    assign bg2pd   = aff_q[0][3];
    assign bg3pa   = aff_q[1][0];
    assign bg3pb   = aff_q[1][1];
    assign bg3pc   = aff_q[1][2];
    assign bg3pd   = aff_q[1][3];
    assign bg2x    = ref_q[0];
    assign bg2y    = ref_q[1];
    assign bg3x    = ref_q[2];
    assign bg3y    = ref_q[3];
endmodule

// File: tb/tb_bg_reg_file.sv
// Self-checking bench for bg_reg_file: directed steps plus random traffic
// checked against a byte-image reference model.
module tb_bg_reg_file;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic vblank_start = 1'b0;
    logic line_done = 1'b0;
    logic [15:0] bg0cnt, bg1cnt, bg2cnt, bg3cnt;
    logic [15:0] bg0hofs, bg1hofs, bg2hofs, bg3hofs;
    logic [15:0] bg0vofs, bg1vofs, bg2vofs, bg3vofs;
    logic [15:0] bg2pa, bg2pb, bg2pc, bg2pd;
    logic [15:0] bg3pa, bg3pb, bg3pc, bg3pd;
    logic [27:0] bg2x, bg2y, bg3x, bg3y;

    bg_reg_file_if #(.ADDR_W(8)) bus ();

    bg_reg_file #(.ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .vblank_start(vblank_start), .line_done(line_done),
        .bg0cnt(bg0cnt), .bg1cnt(bg1cnt), .bg2cnt(bg2cnt), .bg3cnt(bg3cnt),
        .bg0hofs(bg0hofs), .bg1hofs(bg1hofs), .bg2hofs(bg2hofs), .bg3hofs(bg3hofs),
        .bg0vofs(bg0vofs), .bg1vofs(bg1vofs), .bg2vofs(bg2vofs), .bg3vofs(bg3vofs),
        .bg2pa(bg2pa), .bg2pb(bg2pb), .bg2pc(bg2pc), .bg2pd(bg2pd),
        .bg3pa(bg3pa), .bg3pb(bg3pb), .bg3pc(bg3pc), .bg3pd(bg3pd),
        .bg2x(bg2x), .bg2y(bg2y), .bg3x(bg3x), .bg3y(bg3y)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: byte image of everything the CPU wrote (offsets 0..63)
    logic [7:0]  bm[64];
    logic [27:0] mref[4];
    logic [31:0] m_rd;
    logic        m_rv;

    function automatic logic [15:0] hw(input int a);
        return {bm[a+1], bm[a]};
    endfunction

    function automatic int xy_addr(input int k);
        return (k < 2 ? 32'h28 : 32'h38) + (k % 2) * 4;
    endfunction

    function automatic logic [27:0] lat(input int k);
        int b;
        b = xy_addr(k);
        return {bm[b+3][3:0], bm[b+2], bm[b+1], bm[b]};
    endfunction

    function automatic int step_addr(input int k);
        return (k < 2 ? 32'h20 : 32'h30) + ((k % 2) != 0 ? 6 : 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bm[i] = 8'h00;
        bm[8'h21] = 8'h01;
        bm[8'h27] = 8'h01;
        bm[8'h31] = 8'h01;
        bm[8'h37] = 8'h01;
        for (int k = 0; k < 4; k++) mref[k] = '0;
        m_rd = '0;
        m_rv = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] st[4];
        logic [3:0]  wrote;
        int a;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) st[k] = hw(step_addr(k));
        m_rv = bus.rd_en;
        if (bus.rd_en) begin
            a = int'({bus.rd_addr[7:2], 2'b00});
            if (a == 8 || a == 12)
                m_rd = {hw(a + 2) & 16'hFFCF, hw(a) & 16'hFFCF};
            else
                m_rd = 32'h0;
        end
        wrote = '0;
        if (bus.wr_en) begin
            a = int'({bus.wr_addr[7:2], 2'b00});
            if (a >= 8) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wr_be[b]) bm[a+b] = bus.wr_data[8*b +: 8];
                for (int k = 0; k < 4; k++)
                    if (a == xy_addr(k) && bus.wr_be != 4'h0) wrote[k] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (wrote[k] || vblank_start)
                mref[k] = lat(k);
            else if (line_done)
                mref[k] = 28'((int'(mref[k]) + int'($signed(st[k]))) & 32'h0FFF_FFFF);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bg0cnt", 32'(bg0cnt), 32'(hw(8'h08) & 16'hFFCF));
        chk("bg1cnt", 32'(bg1cnt), 32'(hw(8'h0A) & 16'hFFCF));
        chk("bg2cnt", 32'(bg2cnt), 32'(hw(8'h0C) & 16'hFFCF));
        chk("bg3cnt", 32'(bg3cnt), 32'(hw(8'h0E) & 16'hFFCF));
        chk("bg0hofs", 32'(bg0hofs), 32'(hw(8'h10) & 16'h01FF));
        chk("bg0vofs", 32'(bg0vofs), 32'(hw(8'h12) & 16'h01FF));
        chk("bg1hofs", 32'(bg1hofs), 32'(hw(8'h14) & 16'h01FF));
        chk("bg1vofs", 32'(bg1vofs), 32'(hw(8'h16) & 16'h01FF));
        chk("bg2hofs", 32'(bg2hofs), 32'(hw(8'h18) & 16'h01FF));
        chk("bg2vofs", 32'(bg2vofs), 32'(hw(8'h1A) & 16'h01FF));
        chk("bg3hofs", 32'(bg3hofs), 32'(hw(8'h1C) & 16'h01FF));
        chk("bg3vofs", 32'(bg3vofs), 32'(hw(8'h1E) & 16'h01FF));
        chk("bg2pa", 32'(bg2pa), 32'(hw(8'h20)));
        chk("bg2pb", 32'(bg2pb), 32'(hw(8'h22)));
        chk("bg2pc", 32'(bg2pc), 32'(hw(8'h24)));
        chk("bg2pd", 32'(bg2pd), 32'(hw(8'h26)));
        chk("bg3pa", 32'(bg3pa), 32'(hw(8'h30)));
        chk("bg3pb", 32'(bg3pb), 32'(hw(8'h32)));
        chk("bg3pc", 32'(bg3pc), 32'(hw(8'h34)));
        chk("bg3pd", 32'(bg3pd), 32'(hw(8'h36)));
        chk("bg2x", 32'(bg2x), 32'(mref[0]));
        chk("bg2y", 32'(bg2y), 32'(mref[1]));
        chk("bg3x", 32'(bg3x), 32'(mref[2]));
        chk("bg3y", 32'(bg3y), 32'(mref[3]));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        chk("rd_data", bus.rd_data, m_rd);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later,
    // then all one-cycle strobes drop.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        vblank_start = 1'b0;
        line_done = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be = be;
    endtask

    task automatic rd(input logic [7:0] a);
        bus.rd_en = 1'b1;
        bus.rd_addr = a;
    endtask

    initial begin
        logic [27:0] exp_x[4];
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be = '0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        model_reset();

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_bg2pa", 32'(bg2pa), 32'h0100);
        chk("rst_bg3pd", 32'(bg3pd), 32'h0100);
        chk("rst_bg2x", 32'(bg2x), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);

        wr(8'h08, 32'hFFFF_FFFF, 4'b0011);
        tick();
        chk("cnt_mask_bg0", 32'(bg0cnt), 32'hFFCF);
        chk("cnt_be_bg1", 32'(bg1cnt), 32'h0);
        rd(8'h08);
        tick();
        chk("cnt_read_valid", 32'(bus.rd_valid), 32'h1);
        chk("cnt_read_data", bus.rd_data, 32'h0000_FFCF);

        wr(8'h10, 32'h0123_0456, 4'hF);
        tick();
        chk("hofs_9bit", 32'(bg0hofs), 32'h0056);
        chk("vofs_9bit", 32'(bg0vofs), 32'h0123);
        rd(8'h10);
        tick();
        chk("ofs_write_only", bus.rd_data, 32'h0);

        wr(8'h28, 32'h0000_1000, 4'hF);
        tick();
        wr(8'h22, 32'hFF80_0000, 4'b1100);
        tick();
        exp_x[0] = 28'h1000;
        exp_x[1] = 28'h0F80;
        exp_x[2] = 28'h0F00;
        exp_x[3] = 28'h0E80;
        chk("step_0", 32'(bg2x), 32'(exp_x[0]));
        for (int i = 1; i < 4; i++) begin
            line_done = 1'b1;
            tick();
            chk($sformatf("step_%0d", i), 32'(bg2x), 32'(exp_x[i]));
        end
        vblank_start = 1'b1;
        tick();
        chk("vblank_reload", 32'(bg2x), 32'h1000);

        wr(8'h28, 32'h07FF_FFFF, 4'hF);
        tick();
        wr(8'h20, 32'h0001_0000, 4'b1100);
        tick();
        line_done = 1'b1;
        tick();
        chk("wrap", 32'(bg2x), 32'h800_0000);

        wr(8'h34, 32'h0100_0000, 4'b1100);
        tick();
        wr(8'h30, 32'h0040_0000, 4'b1100);
        tick();
        wr(8'h3C, 32'h0000_0200, 4'hF);
        line_done = 1'b1;
        tick();
        chk("write_beats_step", 32'(bg3y), 32'h200);

        vblank_start = 1'b1;
        line_done = 1'b1;
        tick();
        chk("vblank_over_step", 32'(bg3x), 32'(lat(2)));

        // PB written with line_done: step uses old PB (0x0001 -> +1)
        wr(8'h20, 32'h0010_0000, 4'b1100);
        line_done = 1'b1;
        tick();
        chk("old_pb_step", 32'(bg2x), 32'h800_0000);

        wr(8'h08, 32'h1234_5678, 4'hF);
        rd(8'h08);
        tick();
        chk("read_pre_write", bus.rd_data, 32'h0000_FFCF);

        rd(8'h0C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_drops_read", 32'(bus.rd_valid), 32'h0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(8'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0)
                rd(8'($urandom_range(0, 63)));
            vblank_start = ($urandom_range(0, 15) == 0);
            line_done = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
